// File: rtl/ysyx_22041207_decode_stage_if.sv
// Bundle of all non-clock signals between IF, the decode stage and EX.
//   master : the IF/EX side (drives flush, the IF offer and the EX ready)
//   slave  : the decode stage (drives in_ready, count and the decoded bundle)
// Parameters must match those of the decode stage instance it is bound to.
interface ysyx_22041207_decode_stage_if #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [31:0]       in_inst;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_imm;
  logic [4:0]        out_rs1;
  logic [4:0]        out_rs2;
  logic [4:0]        out_rd;
  logic [4:0]        out_alu_op;
  logic [1:0]        out_sel_a;
  logic [1:0]        out_sel_b;
  logic              out_wen_rd;
  logic [2:0]        out_wb_sel;
  logic              out_mem_ren;
  logic [XLEN/8-1:0] out_mem_wmask;
  logic [3:0]        out_ld_bytes;
  logic              out_ld_sext;
  logic              out_word_op;
  logic              out_branch;
  logic              out_jal;
  logic              out_jalr;
  logic              out_csr_wen;
  logic [1:0]        out_sys;
  logic              out_illegal;
  logic [CW-1:0]     count;

  modport master (
    output flush, in_valid, in_pc, in_inst, out_ready,
    input  in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_alu_op, out_sel_a, out_sel_b, out_wen_rd, out_wb_sel,
           out_mem_ren, out_mem_wmask, out_ld_bytes, out_ld_sext, out_word_op,
           out_branch, out_jal, out_jalr, out_csr_wen, out_sys, out_illegal, count
  );

  modport slave (
    input  flush, in_valid, in_pc, in_inst, out_ready,
    output in_ready, out_valid, out_pc, out_imm, out_rs1, out_rs2, out_rd,
           out_alu_op, out_sel_a, out_sel_b, out_wen_rd, out_wb_sel,
           out_mem_ren, out_mem_wmask, out_ld_bytes, out_ld_sext, out_word_op,
           out_branch, out_jal, out_jalr, out_csr_wen, out_sys, out_illegal, count
  );
endinterface

// File: rtl/ysyx_22041207_decode_stage.sv
// Buffered RV decode stage between IF and EX.
// {pc, inst} from IF enter a DEPTH-entry queue; the queue head is decoded
// combinationally and loaded into a single registered output slot whenever
// the slot is empty or being consumed. Up to DEPTH+1 instructions in flight.
// Ports:
//   clk    - clock, all state on posedge
//   rst_n  - asynchronous active-low reset
//   dec_if - slave side of the stage interface (IF offer, EX bundle, flush, count)
// ALU op codes (shared with EX):
//   0 ADD 1 SUB 2 SLL 3 SLT 4 SLTU 5 XOR 6 SRL 7 SRA 8 OR 9 AND
//   10 EQ 11 LOE(>=) 12 LOEU 13 MUL 14 MULH 15 MULHSU 16 MULHU
//   17 DIV 18 DIVU 19 REM 20 REMU 21 PASSB 22 PASSA 23 ANDN(~a & b)
// sel_a=2 selects the zero-extended rs1 field (CSR immediate forms),
// since out_imm already carries the CSR address there.
module ysyx_22041207_decode_stage #(
  parameter int XLEN  = 64,
  parameter int DEPTH = 2,
  parameter bit EN_M  = 1'b1
) (
  input logic clk,
  input logic rst_n,
  ysyx_22041207_decode_stage_if.slave dec_if
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam bit RV64 = (XLEN == 64);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  localparam logic [4:0] ALU_ADD = 5'd0,  ALU_SUB = 5'd1,  ALU_SLL = 5'd2,  ALU_SLT = 5'd3;
  localparam logic [4:0] ALU_SLTU = 5'd4, ALU_XOR = 5'd5,  ALU_SRL = 5'd6,  ALU_SRA = 5'd7;
  localparam logic [4:0] ALU_OR = 5'd8,   ALU_AND = 5'd9,  ALU_EQ = 5'd10,  ALU_LOE = 5'd11;
  localparam logic [4:0] ALU_LOEU = 5'd12, ALU_MUL = 5'd13, ALU_DIV = 5'd17;
  localparam logic [4:0] ALU_PASSB = 5'd21, ALU_PASSA = 5'd22, ALU_ANDN = 5'd23;

  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23, OP_IMM = 7'h13;
  localparam logic [6:0] OP_IMM32 = 7'h1B, OP_OP = 7'h33, OP_OP32 = 7'h3B, OP_SYS = 7'h73;
  localparam logic [6:0] OP_FENCE = 7'h0F;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [4:0]        alu_op;
    logic [1:0]        sel_a;
    logic [1:0]        sel_b;
    logic              wen_rd;
    logic [2:0]        wb_sel;
    logic              mem_ren;
    logic [XLEN/8-1:0] wmask;
    logic [3:0]        ld_bytes;
    logic              ld_sext;
    logic              word_op;
    logic              branch;
    logic              jal;
    logic              jalr;
    logic              csr_wen;
    logic [1:0]        sys;
    logic              illegal;
  } bundle_t;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [31:0]     inst_mem [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;
  bundle_t         slot_q, slot_d, dec;
  logic            push, advance;

  logic [XLEN-1:0] head_pc;
  logic [31:0]     head_inst;
  logic [6:0]      opcode, funct7;
  logic [2:0]      funct3;
  logic [63:0]     imm_i64, imm_s64, imm_b64, imm_u64, imm_j64;
  logic [7:0]      wmask8;

  assign head_pc   = pc_mem[rd_ptr_q];
  assign head_inst = inst_mem[rd_ptr_q];
  assign opcode    = head_inst[6:0];
  assign funct3    = head_inst[14:12];
  assign funct7    = head_inst[31:25];

  assign imm_i64 = {{52{head_inst[31]}}, head_inst[31:20]};
  assign imm_s64 = {{52{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
  assign imm_b64 = {{52{head_inst[31]}}, head_inst[7], head_inst[30:25], head_inst[11:8], 1'b0};
  assign imm_u64 = {{32{head_inst[31]}}, head_inst[31:12], 12'h000};
  assign imm_j64 = {{44{head_inst[31]}}, head_inst[19:12], head_inst[20], head_inst[30:21], 1'b0};

  // ready is purely occupancy based so IF never waits on EX combinationally
  assign dec_if.in_ready = (count_q < CNT_MAX);
  assign push    = dec_if.in_valid && dec_if.in_ready;
  assign advance = (count_q != '0) && (!valid_q || dec_if.out_ready);

  always_comb begin
    dec        = '0;
    wmask8     = 8'h00;
    dec.pc     = head_pc;
    dec.rs1    = head_inst[19:15];
    dec.rs2    = head_inst[24:20];
    dec.rd     = head_inst[11:7];
    dec.alu_op = ALU_ADD;
    dec.sel_a  = 2'd1;
    case (opcode)
      OP_LUI: begin
        dec.imm = imm_u64[XLEN-1:0]; dec.alu_op = ALU_PASSB; dec.wen_rd = 1'b1;
      end
      OP_AUIPC: begin
        dec.imm = imm_u64[XLEN-1:0]; dec.sel_a = 2'd0; dec.wen_rd = 1'b1;
      end
      OP_JAL: begin
        dec.imm = imm_j64[XLEN-1:0]; dec.sel_a = 2'd0; dec.wb_sel = 3'd2;
        dec.jal = 1'b1; dec.wen_rd = 1'b1;
      end
      OP_JALR: begin
        dec.imm = imm_i64[XLEN-1:0]; dec.wb_sel = 3'd2; dec.jalr = 1'b1; dec.wen_rd = 1'b1;
        dec.illegal = (funct3 != 3'd0);
      end
      OP_BR: begin
        // EX takes the branch when the ALU result is zero
        dec.imm = imm_b64[XLEN-1:0]; dec.sel_b = 2'd1; dec.branch = 1'b1;
        case (funct3)
          3'd0: dec.alu_op = ALU_XOR;
          3'd1: dec.alu_op = ALU_EQ;
          3'd4: dec.alu_op = ALU_LOE;
          3'd5: dec.alu_op = ALU_SLT;
          3'd6: dec.alu_op = ALU_LOEU;
          3'd7: dec.alu_op = ALU_SLTU;
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.imm = imm_i64[XLEN-1:0]; dec.mem_ren = 1'b1; dec.wb_sel = 3'd1; dec.wen_rd = 1'b1;
        case (funct3)
          3'd0: begin dec.ld_bytes = 4'd1; dec.ld_sext = 1'b1; end
          3'd1: begin dec.ld_bytes = 4'd2; dec.ld_sext = 1'b1; end
          3'd2: begin dec.ld_bytes = 4'd4; dec.ld_sext = 1'b1; end
          3'd3: begin dec.ld_bytes = 4'd8; dec.illegal = !RV64; end
          3'd4: dec.ld_bytes = 4'd1;
          3'd5: dec.ld_bytes = 4'd2;
          3'd6: begin dec.ld_bytes = 4'd4; dec.illegal = !RV64; end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_STORE: begin
        dec.imm = imm_s64[XLEN-1:0];
        case (funct3)
          3'd0: wmask8 = 8'h01;
          3'd1: wmask8 = 8'h03;
          3'd2: wmask8 = 8'h0F;
          3'd3: begin wmask8 = 8'hFF; dec.illegal = !RV64; end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.imm = imm_i64[XLEN-1:0]; dec.wen_rd = 1'b1;
        case (funct3)
          3'd0: dec.alu_op = ALU_ADD;
          3'd2: dec.alu_op = ALU_SLT;
          3'd3: dec.alu_op = ALU_SLTU;
          3'd4: dec.alu_op = ALU_XOR;
          3'd6: dec.alu_op = ALU_OR;
          3'd7: dec.alu_op = ALU_AND;
          3'd1: begin
            dec.alu_op  = ALU_SLL;
            dec.illegal = (head_inst[31:26] != 6'b000000) || (!RV64 && head_inst[25]);
          end
          default: begin
            dec.alu_op  = head_inst[30] ? ALU_SRA : ALU_SRL;
            dec.illegal = ((head_inst[31:26] & 6'b101111) != 6'b000000) || (!RV64 && head_inst[25]);
          end
        endcase
      end
      OP_IMM32: begin
        dec.imm = imm_i64[XLEN-1:0]; dec.wen_rd = 1'b1; dec.word_op = 1'b1; dec.wb_sel = 3'd4;
        dec.illegal = !RV64;
        case (funct3)
          3'd0: dec.alu_op = ALU_ADD;
          3'd1: begin dec.alu_op = ALU_SLL; if (funct7 != 7'h00) dec.illegal = 1'b1; end
          3'd5: begin
            dec.alu_op = head_inst[30] ? ALU_SRA : ALU_SRL;
            if (funct7 != 7'h00 && funct7 != 7'h20) dec.illegal = 1'b1;
          end
          default: dec.illegal = 1'b1;
        endcase
      end
      OP_OP: begin
        dec.sel_b = 2'd1; dec.wen_rd = 1'b1;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'd0: dec.alu_op = ALU_ADD;
            3'd1: dec.alu_op = ALU_SLL;
            3'd2: dec.alu_op = ALU_SLT;
            3'd3: dec.alu_op = ALU_SLTU;
            3'd4: dec.alu_op = ALU_XOR;
            3'd5: dec.alu_op = ALU_SRL;
            3'd6: dec.alu_op = ALU_OR;
            default: dec.alu_op = ALU_AND;
          endcase
        end else if (funct7 == 7'h20 && funct3 == 3'd0) dec.alu_op = ALU_SUB;
        else if (funct7 == 7'h20 && funct3 == 3'd5) dec.alu_op = ALU_SRA;
        // M ops are numbered in funct3 order starting at MUL
        else if (funct7 == 7'h01 && EN_M) dec.alu_op = ALU_MUL + {2'b00, funct3};
        else dec.illegal = 1'b1;
      end
      OP_OP32: begin
        dec.sel_b = 2'd1; dec.wen_rd = 1'b1; dec.word_op = 1'b1; dec.wb_sel = 3'd4;
        dec.illegal = !RV64;
        if (funct7 == 7'h00 && funct3 == 3'd0) dec.alu_op = ALU_ADD;
        else if (funct7 == 7'h00 && funct3 == 3'd1) dec.alu_op = ALU_SLL;
        else if (funct7 == 7'h00 && funct3 == 3'd5) dec.alu_op = ALU_SRL;
        else if (funct7 == 7'h20 && funct3 == 3'd0) dec.alu_op = ALU_SUB;
        else if (funct7 == 7'h20 && funct3 == 3'd5) dec.alu_op = ALU_SRA;
        else if (funct7 == 7'h01 && EN_M && funct3 == 3'd0) dec.alu_op = ALU_MUL;
        else if (funct7 == 7'h01 && EN_M && funct3[2]) dec.alu_op = ALU_DIV + {3'b000, funct3[1:0]};
        else dec.illegal = 1'b1;
      end
      OP_SYS: begin
        dec.imm = imm_i64[XLEN-1:0];
        case (funct3)
          3'd0: begin
            if (head_inst[31:20] == 12'h000) dec.sys = 2'd2;
            else if (head_inst[31:20] == 12'h001) dec.sys = 2'd1;
            else if (head_inst[31:20] == 12'h302) dec.sys = 2'd3;
            else dec.illegal = 1'b1;
          end
          3'd4: dec.illegal = 1'b1;
          default: begin
            // rs1 field is the source register or the 5-bit zimm; zero means read-only for set/clear
            dec.sel_a   = funct3[2] ? 2'd2 : 2'd1;
            dec.sel_b   = 2'd3;
            dec.wb_sel  = 3'd5;
            dec.wen_rd  = 1'b1;
            dec.alu_op  = (funct3[1:0] == 2'd1) ? ALU_PASSA :
                          (funct3[1:0] == 2'd2) ? ALU_OR : ALU_ANDN;
            dec.csr_wen = (funct3[1:0] == 2'd1) || (head_inst[19:15] != 5'd0);
          end
        endcase
      end
      OP_FENCE: ;
      default: dec.illegal = 1'b1;
    endcase
    dec.wmask = wmask8[XLEN/8-1:0];
    if (dec.rd == 5'd0) dec.wen_rd = 1'b0;
    if (dec.illegal) begin
      dec.wen_rd = 1'b0; dec.mem_ren = 1'b0; dec.wmask = '0; dec.csr_wen = 1'b0;
      dec.branch = 1'b0; dec.jal = 1'b0; dec.jalr = 1'b0; dec.sys = 2'd0;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    slot_d   = slot_q;
    if (dec_if.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (advance) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        slot_d   = dec;
        valid_d  = 1'b1;
      end else if (dec_if.out_ready) begin
        valid_d = 1'b0;
      end
      case ({push, advance})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !dec_if.flush) begin
      pc_mem[wr_ptr_q]   <= dec_if.in_pc;
      inst_mem[wr_ptr_q] <= dec_if.in_inst;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      slot_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      slot_q   <= slot_d;
    end
  end

  assign dec_if.count         = count_q;
  assign dec_if.out_valid     = valid_q;
  assign dec_if.out_pc        = slot_q.pc;
  assign dec_if.out_imm       = slot_q.imm;
  assign dec_if.out_rs1       = slot_q.rs1;
  assign dec_if.out_rs2       = slot_q.rs2;
  assign dec_if.out_rd        = slot_q.rd;
  assign dec_if.out_alu_op    = slot_q.alu_op;
  assign dec_if.out_sel_a     = slot_q.sel_a;
  assign dec_if.out_sel_b     = slot_q.sel_b;
  assign dec_if.out_wen_rd    = slot_q.wen_rd;
  assign dec_if.out_wb_sel    = slot_q.wb_sel;
  assign dec_if.out_mem_ren   = slot_q.mem_ren;
  assign dec_if.out_mem_wmask = slot_q.wmask;
  assign dec_if.out_ld_bytes  = slot_q.ld_bytes;
  assign dec_if.out_ld_sext   = slot_q.ld_sext;
  assign dec_if.out_word_op   = slot_q.word_op;
  assign dec_if.out_branch    = slot_q.branch;
  assign dec_if.out_jal       = slot_q.jal;
  assign dec_if.out_jalr      = slot_q.jalr;
  assign dec_if.out_csr_wen   = slot_q.csr_wen;
  assign dec_if.out_sys       = slot_q.sys;
  assign dec_if.out_illegal   = slot_q.illegal;
endmodule

// File: tb/tb_ysyx_22041207_decode_stage.sv
// Directed bench: an RV64 instance drives the stimulus; an RV32 instance and an
// RV64 no-M instance receive the same input stream so width/extension
// differences can be checked on identical instructions.
module tb_ysyx_22041207_decode_stage;
  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SLT = 5'd3, ALU_MUL = 5'd13;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   n_acc;

  ysyx_22041207_decode_stage_if #(.XLEN(64), .DEPTH(2)) bus64 ();
  ysyx_22041207_decode_stage_if #(.XLEN(32), .DEPTH(2)) bus32 ();
  ysyx_22041207_decode_stage_if #(.XLEN(64), .DEPTH(2)) busnm ();

  assign bus32.flush     = bus64.flush;
  assign bus32.in_valid  = bus64.in_valid;
  assign bus32.in_pc     = bus64.in_pc[31:0];
  assign bus32.in_inst   = bus64.in_inst;
  assign bus32.out_ready = bus64.out_ready;
  assign busnm.flush     = bus64.flush;
  assign busnm.in_valid  = bus64.in_valid;
  assign busnm.in_pc     = bus64.in_pc;
  assign busnm.in_inst   = bus64.in_inst;
  assign busnm.out_ready = bus64.out_ready;

  ysyx_22041207_decode_stage #(.XLEN(64), .DEPTH(2), .EN_M(1'b1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .dec_if(bus64));
  ysyx_22041207_decode_stage #(.XLEN(32), .DEPTH(2), .EN_M(1'b1)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .dec_if(bus32));
  ysyx_22041207_decode_stage #(.XLEN(64), .DEPTH(2), .EN_M(1'b0)) u_dutnm (
    .clk(clk), .rst_n(rst_n), .dec_if(busnm));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // push one instruction with an empty pipe; returns when it sits in the slot
  task automatic issue(input logic [63:0] pc, input logic [31:0] inst);
    bus64.in_pc    = pc;
    bus64.in_inst  = inst;
    bus64.in_valid = 1'b1;
    step();
    bus64.in_valid = 1'b0;
    step();
    $display("issue pc=0x%0h inst=0x%08h valid=%0d", pc, inst, bus64.out_valid);
  endtask

  // offer addi x(k+1),x0,k+1 for k=0..3, each held for one cycle; counts acceptances
  task automatic fill(input logic [63:0] base, output int acc_cnt);
    logic acc;
    acc_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      bus64.in_pc    = base + 64'(4 * k);
      bus64.in_inst  = 32'(((k + 1) << 20) | ((k + 1) << 7) | 32'h13);
      bus64.in_valid = 1'b1;
      acc = bus64.in_ready;
      step();
      if (acc) acc_cnt++;
      $display("fill k=%0d accepted=%0d count=%0d", k, acc, bus64.count);
    end
    bus64.in_valid = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    bus64.flush     = 1'b0;
    bus64.in_valid  = 1'b0;
    bus64.in_pc     = '0;
    bus64.in_inst   = '0;
    bus64.out_ready = 1'b1;
    #1;
    chk("rst_valid", 64'(bus64.out_valid), 64'd0);
    chk("rst_count", 64'(bus64.count), 64'd0);
    chk("rst_ready", 64'(bus64.in_ready), 64'd1);
    #11 rst_n = 1'b1;
    step();

    // addi x1,x0,5 : one cycle in the queue, then in the slot
    bus64.in_pc = 64'h8000_0000; bus64.in_inst = 32'h00500093; bus64.in_valid = 1'b1;
    step();
    bus64.in_valid = 1'b0;
    chk("addi_n_count", 64'(bus64.count), 64'd1);
    chk("addi_n_valid", 64'(bus64.out_valid), 64'd0);
    step();
    $display("addi pc=0x%0h rd=%0d imm=%0d", bus64.out_pc, bus64.out_rd, bus64.out_imm);
    chk("addi_valid", 64'(bus64.out_valid), 64'd1);
    chk("addi_pc", bus64.out_pc, 64'h8000_0000);
    chk("addi_rd", 64'(bus64.out_rd), 64'd1);
    chk("addi_imm", bus64.out_imm, 64'd5);
    chk("addi_alu", 64'(bus64.out_alu_op), 64'(ALU_ADD));
    chk("addi_sel_a", 64'(bus64.out_sel_a), 64'd1);
    chk("addi_sel_b", 64'(bus64.out_sel_b), 64'd0);
    chk("addi_wen", 64'(bus64.out_wen_rd), 64'd1);

    // sd x1,8(x2)
    issue(64'h8000_0004, 32'h00113423);
    chk("sd_wmask", 64'(bus64.out_mem_wmask), 64'hFF);
    chk("sd_imm", bus64.out_imm, 64'd8);
    chk("sd_rs1", 64'(bus64.out_rs1), 64'd2);
    chk("sd_rs2", 64'(bus64.out_rs2), 64'd1);
    chk("sd_wen", 64'(bus64.out_wen_rd), 64'd0);
    chk("sd_illegal", 64'(bus64.out_illegal), 64'd0);
    chk("sd32_illegal", 64'(bus32.out_illegal), 64'd1);
    chk("sd32_wmask", 64'(bus32.out_mem_wmask), 64'd0);

    // backpressure: 3 of 4 accepted, then drained in order
    step();
    bus64.out_ready = 1'b0;
    fill(64'h1000, n_acc);
    chk("bp_accepted", 64'(n_acc), 64'd3);
    chk("bp_in_ready", 64'(bus64.in_ready), 64'd0);
    chk("bp_count", 64'(bus64.count), 64'd2);
    chk("bp_valid", 64'(bus64.out_valid), 64'd1);
    chk("bp_pc0", bus64.out_pc, 64'h1000);
    step();
    chk("stall_pc", bus64.out_pc, 64'h1000);
    chk("stall_imm", bus64.out_imm, 64'd1);
    chk("stall_rd", 64'(bus64.out_rd), 64'd1);
    bus64.out_ready = 1'b1;
    step();
    chk("drain1_pc", bus64.out_pc, 64'h1004);
    chk("drain1_rd", 64'(bus64.out_rd), 64'd2);
    chk("drain1_count", 64'(bus64.count), 64'd1);
    step();
    chk("drain2_pc", bus64.out_pc, 64'h1008);
    chk("drain2_imm", bus64.out_imm, 64'd3);
    chk("drain2_count", 64'(bus64.count), 64'd0);
    step();
    chk("drain_empty", 64'(bus64.out_valid), 64'd0);

    // addw x3,x1,x2
    issue(64'h2000, 32'h002081bb);
    chk("addw_word", 64'(bus64.out_word_op), 64'd1);
    chk("addw_wb", 64'(bus64.out_wb_sel), 64'd4);
    chk("addw_alu", 64'(bus64.out_alu_op), 64'(ALU_ADD));
    chk("addw_wen", 64'(bus64.out_wen_rd), 64'd1);
    chk("addw32_illegal", 64'(bus32.out_illegal), 64'd1);
    chk("addw32_wen", 64'(bus32.out_wen_rd), 64'd0);

    // mul x5,x6,x7
    issue(64'h2004, 32'h027302B3);
    chk("mul_alu", 64'(bus64.out_alu_op), 64'(ALU_MUL));
    chk("mul_illegal", 64'(bus64.out_illegal), 64'd0);
    chk("mulnm_illegal", 64'(busnm.out_illegal), 64'd1);
    chk("mulnm_wen", 64'(busnm.out_wen_rd), 64'd0);

    // bge x1,x2,+16
    issue(64'h2008, 32'h0020D863);
    chk("bge_alu", 64'(bus64.out_alu_op), 64'(ALU_SLT));
    chk("bge_branch", 64'(bus64.out_branch), 64'd1);
    chk("bge_imm", bus64.out_imm, 64'd16);
    chk("bge_sel_b", 64'(bus64.out_sel_b), 64'd1);

    // system and CSR
    issue(64'h3000, 32'h00000073);
    chk("ecall_sys", 64'(bus64.out_sys), 64'd2);
    issue(64'h3004, 32'h00100073);
    chk("ebreak_sys", 64'(bus64.out_sys), 64'd1);
    issue(64'h3008, 32'h30200073);
    chk("mret_sys", 64'(bus64.out_sys), 64'd3);
    chk("mret_illegal", 64'(bus64.out_illegal), 64'd0);
    issue(64'h300C, 32'h10500073);
    chk("wfi_illegal", 64'(bus64.out_illegal), 64'd1);
    chk("wfi_sys", 64'(bus64.out_sys), 64'd0);
    issue(64'h3010, 32'h305110F3);
    chk("csrrw_wen", 64'(bus64.out_csr_wen), 64'd1);
    chk("csrrw_wb", 64'(bus64.out_wb_sel), 64'd5);
    chk("csrrw_sel_b", 64'(bus64.out_sel_b), 64'd3);
    issue(64'h3014, 32'h300020F3);
    chk("csrrs_x0_wen", 64'(bus64.out_csr_wen), 64'd0);

    // flush with full queue and a simultaneous offer
    step();
    bus64.out_ready = 1'b0;
    fill(64'h4000, n_acc);
    bus64.flush = 1'b1; bus64.in_valid = 1'b1; bus64.in_inst = 32'h00900313;
    step();
    bus64.flush = 1'b0; bus64.in_valid = 1'b0;
    $display("flush count=%0d valid=%0d", bus64.count, bus64.out_valid);
    chk("flush_count", 64'(bus64.count), 64'd0);
    chk("flush_valid", 64'(bus64.out_valid), 64'd0);
    chk("flush_ready", 64'(bus64.in_ready), 64'd1);
    bus64.out_ready = 1'b1;
    issue(64'h9000, 32'h00700293);
    chk("post_flush_pc", bus64.out_pc, 64'h9000);
    chk("post_flush_rd", 64'(bus64.out_rd), 64'd5);
    chk("post_flush_imm", bus64.out_imm, 64'd7);

    // asynchronous reset mid-stream with 2 queued
    step();
    bus64.out_ready = 1'b0;
    fill(64'h5000, n_acc);
    chk("pre_rst_count", 64'(bus64.count), 64'd2);
    rst_n = 1'b0;
    #2;
    $display("async reset count=%0d valid=%0d", bus64.count, bus64.out_valid);
    chk("arst_valid", 64'(bus64.out_valid), 64'd0);
    chk("arst_count", 64'(bus64.count), 64'd0);
    chk("arst_ready", 64'(bus64.in_ready), 64'd1);
    chk("arst_imm", bus64.out_imm, 64'd0);
    chk("arst_rd", 64'(bus64.out_rd), 64'd0);
    #10 rst_n = 1'b1;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
